// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
//   Sequential front-end for a combinational ALU. Accepts commands on a
//   valid/ready stream and registers operands and select toward the ALU.
//   One cycle later it captures the ALU result into a running accumulator
//   and into a small response FIFO. That FIFO drains on a valid/ready
//   response stream.
//
//   Optional build macro: ALU_SEQ_OVERFLOW_EN
//     defined   - each FIFO entry carries a signed-overflow bit for add/sub,
//                 and rsp_ovf presents the head entry's bit
//     undefined - no overflow storage; rsp_ovf is tied to 0
//
// Ports
//   clk, rstn                     clock, synchronous active-low reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_op, cmd_a, cmd_b          op select (0 add, 1 or, 2 and, 3 sub) and operands
//   cmd_use_acc                   substitute the accumulator for cmd_a
//   alu_a, alu_b, alu_sel         registered operands/select driven to the ALU
//   alu_out                       combinational ALU result
//   rsp_valid/rsp_ready           response handshake (FIFO non-empty / pop)
//   rsp_data, rsp_zero, rsp_ovf   head result, result==0, signed overflow
//   acc                           current accumulator value
module alu_cmd_sequencer #(
    parameter int WIDTH      = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_use_acc,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero,
    output logic             rsp_ovf,
    output logic [WIDTH-1:0] acc
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EXEC = 1'b1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [0:0]       state;
    logic             accept;
    logic             push;
    logic             pop;
    logic             nonempty;
    logic [WIDTH-1:0] res_p1;
    logic             zero_p1;

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] data_mem [FIFO_DEPTH];
    logic             zero_mem [FIFO_DEPTH];

    // Only ops 0..3 are defined; anything else yields 0 regardless of what
    // the attached ALU happens to produce for that select.
    function automatic logic [WIDTH-1:0] mask_result(input logic [3:0] sel,
                                                     input logic [WIDTH-1:0] r);
        return (sel[3:2] == 2'b00) ? r : '0;
    endfunction

`ifdef ALU_SEQ_OVERFLOW_EN
    logic ovf_mem [FIFO_DEPTH];
    logic ovf_p1;

    // Two's-complement overflow: operands of the same sign (add) or of
    // opposite sign (sub) whose result sign differs from operand a.
    function automatic logic signed_ovf(input logic [3:0] sel,
                                        input logic signed [WIDTH-1:0] a,
                                        input logic signed [WIDTH-1:0] b,
                                        input logic signed [WIDTH-1:0] r);
        case (sel)
            4'd0:    return (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            4'd3:    return (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            default: return 1'b0;
        endcase
    endfunction
`endif

    // Ready depends only on state and occupancy, never on cmd_valid.
    assign cmd_ready = (state == IDLE) && (count < CW'(FIFO_DEPTH));
    assign accept    = cmd_valid && cmd_ready;
    assign push      = (state == EXEC);
    assign nonempty  = (count != '0);
    assign pop       = nonempty && rsp_ready;
    assign res_p1    = mask_result(alu_sel, alu_out);
    assign zero_p1   = (res_p1 == '0);

    // p0: command acceptance, operands registered toward the ALU
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= IDLE;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_sel <= '0;
            acc     <= '0;
        end else if (state == IDLE) begin
            if (accept) begin
                alu_a   <= cmd_use_acc ? acc : cmd_a;
                alu_b   <= cmd_b;
                alu_sel <= cmd_op;
                state   <= EXEC;
            end
        end else begin
            // p1: ALU result captured into the accumulator
            acc   <= res_p1;
            state <= IDLE;
        end
    end

    // response FIFO control
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // response FIFO storage (no reset; the head is masked while empty)
    always_ff @(posedge clk) begin
        if (push && rstn) begin
            data_mem[wr_ptr] <= res_p1;
            zero_mem[wr_ptr] <= zero_p1;
        end
    end

    assign rsp_valid = nonempty;
    assign rsp_data  = nonempty ? data_mem[rd_ptr] : '0;
    assign rsp_zero  = nonempty ? zero_mem[rd_ptr] : 1'b0;

`ifdef ALU_SEQ_OVERFLOW_EN
    assign ovf_p1 = signed_ovf(alu_sel, alu_a, alu_b, res_p1);

    always_ff @(posedge clk) begin
        if (push && rstn) begin
            ovf_mem[wr_ptr] <= ovf_p1;
        end
    end

    assign rsp_ovf = nonempty ? ovf_mem[rd_ptr] : 1'b0;
`else
    assign rsp_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
`timescale 1ns/1ps
module tb_alu_cmd_sequencer;
    localparam int W = 32;
    localparam int D = 2;
`ifdef ALU_SEQ_OVERFLOW_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [3:0]   cmd_op = '0;
    logic [W-1:0] cmd_a = '0;
    logic [W-1:0] cmd_b = '0;
    logic         cmd_use_acc = 1'b0;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [3:0]   alu_sel;
    logic [W-1:0] alu_out;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] rsp_data;
    logic         rsp_zero;
    logic         rsp_ovf;
    logic [W-1:0] acc;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.WIDTH(W), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf), .acc(acc)
    );

    // Combinational ALU attached to the sequencer
    function automatic logic [W-1:0] alu_fn(input logic [3:0] op,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a | b;
            4'd2:    return a & b;
            4'd3:    return a - b;
            default: return '0;
        endcase
    endfunction

    always_comb alu_out = alu_fn(alu_sel, alu_a, alu_b);

    // Overflow from exact signed arithmetic: is the true result representable?
    function automatic logic ovf_fn(input logic [3:0] op,
                                    input logic [W-1:0] a,
                                    input logic [W-1:0] b);
        longint sa, sb, s, hi, lo;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        hi = (longint'(1) <<< (W - 1)) - 1;
        lo = -(longint'(1) <<< (W - 1));
        if (op == 4'd0)      s = sa + sb;
        else if (op == 4'd3) s = sa - sb;
        else                 return 1'b0;
        return OVF_EXP && ((s > hi) || (s < lo));
    endfunction

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one op in flight, results queued in command order
    logic [W-1:0] qd[$];
    logic         qo[$];
    bit           m_busy = 1'b0;
    logic [W-1:0] m_pend = '0;
    logic         m_pend_ovf = 1'b0;
    logic [W-1:0] m_acc = '0;
    logic [W-1:0] m_a = '0;
    logic [W-1:0] m_b = '0;
    logic [3:0]   m_sel = '0;
    bit           m_pop;
    bit           m_rdy;
    int           m_pre;
    logic [W-1:0] m_ea;

    always @(posedge clk) begin
        if (!rstn) begin
            qd.delete();
            qo.delete();
            m_busy = 1'b0;
            m_acc  = '0;
            m_a    = '0;
            m_b    = '0;
            m_sel  = '0;
        end else begin
            m_pre = qd.size();
            m_pop = (m_pre > 0) && rsp_ready;
            m_rdy = !m_busy && (m_pre < D);
            if (m_pop) begin
                void'(qd.pop_front());
                void'(qo.pop_front());
            end
            if (m_busy) begin
                total++;
                if (m_pre >= D) begin
                    bad++;
                    $display("FAIL push_full: occupancy %0d required below %0d at %0t", m_pre, D, $time);
                end
                qd.push_back(m_pend);
                qo.push_back(m_pend_ovf);
                m_acc  = m_pend;
                m_busy = 1'b0;
            end else if (cmd_valid && m_rdy) begin
                m_ea       = cmd_use_acc ? m_acc : cmd_a;
                m_a        = m_ea;
                m_b        = cmd_b;
                m_sel      = cmd_op;
                m_pend     = alu_fn(cmd_op, m_ea, cmd_b);
                m_pend_ovf = ovf_fn(cmd_op, m_ea, cmd_b);
                m_busy     = 1'b1;
            end
        end
    end

    // Compare process: every cycle, on the falling edge
    logic [W-1:0] e_data;
    logic         e_zero;
    logic         e_ovf;
    always @(negedge clk) begin
        if (chk_en) begin
            e_data = '0;
            e_zero = 1'b0;
            e_ovf  = 1'b0;
            if (qd.size() > 0) begin
                e_data = qd[0];
                e_zero = (qd[0] == '0);
                e_ovf  = qo[0];
            end
            chk("m_cmd_ready", W'(cmd_ready), W'(!m_busy && (qd.size() < D)));
            chk("m_rsp_valid", W'(rsp_valid), W'(qd.size() > 0));
            chk("m_rsp_data",  rsp_data, e_data);
            chk("m_rsp_zero",  W'(rsp_zero), W'(e_zero));
            chk("m_rsp_ovf",   W'(rsp_ovf), W'(e_ovf));
            chk("m_acc",       acc, m_acc);
            chk("m_alu_a",     alu_a, m_a);
            chk("m_alu_b",     alu_b, m_b);
            chk("m_alu_sel",   W'(alu_sel), W'(m_sel));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Present a command and hold it until accepted (bounded wait)
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic u);
        int n;
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = u; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) begin
            total++;
            bad++;
            $display("FAIL issue_timeout: cmd_ready stayed 0, required 1 within 50 cycles");
        end
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic issue_chk(input logic [3:0] op, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic u,
                             input logic [W-1:0] exp, input logic expz);
        issue(op, a, b, u);
        step();
        chk("d_rsp_valid", W'(rsp_valid), W'(1));
        chk("d_rsp_data",  rsp_data, exp);
        chk("d_rsp_zero",  W'(rsp_zero), W'(expz));
        chk("d_acc",       acc, exp);
    endtask

    initial begin
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rstn = 1'b1;
        chk_en = 1'b1;
        chk("rst_cmd_ready", W'(cmd_ready), W'(1));
        chk("rst_rsp_valid", W'(rsp_valid), W'(0));
        chk("rst_acc",       acc, '0);
        chk("rst_alu_sel",   W'(alu_sel), W'(0));

        // single add
        rsp_ready = 1'b1;
        issue(4'd0, 32'd5, 32'd7, 1'b0);
        chk("add_alu_sel", W'(alu_sel), W'(0));
        chk("add_alu_a",   alu_a, 32'd5);
        chk("add_busy",    W'(cmd_ready), W'(0));
        step();
        chk("add_valid", W'(rsp_valid), W'(1));
        chk("add_data",  rsp_data, 32'd12);
        chk("add_zero",  W'(rsp_zero), W'(0));
        chk("add_acc",   acc, 32'd12);

        // sub to zero, then accumulator chain
        issue_chk(4'd3, 32'd9, 32'd9, 1'b0, 32'd0, 1'b1);
        issue_chk(4'd1, 32'hDEAD, 32'hF0, 1'b1, 32'hF0, 1'b0);
        issue_chk(4'd2, 32'h0, 32'h30, 1'b1, 32'h30, 1'b0);
        step();

        // backpressure
        rsp_ready = 1'b0;
        issue(4'd0, 32'd1, 32'd1, 1'b0);
        issue(4'd0, 32'd2, 32'd2, 1'b0);
        step();
        chk("bp_full_ready", W'(cmd_ready), W'(0));
        cmd_op = 4'd0; cmd_a = 32'd3; cmd_b = 32'd3; cmd_use_acc = 1'b0; cmd_valid = 1'b1;
        step();
        step();
        chk("bp_hold_ready", W'(cmd_ready), W'(0));
        chk("bp_head",       rsp_data, 32'd2);
        rsp_ready = 1'b1;
        step();
        chk("bp_second", rsp_data, 32'd4);
        chk("bp_reopen", W'(cmd_ready), W'(1));
        step();
        cmd_valid = 1'b0;
        chk("bp_third_acc", alu_a, 32'd3);
        chk("bp_empty",     W'(rsp_valid), W'(0));
        step();
        chk("bp_third", rsp_data, 32'd6);
        chk("bp_acc",   acc, 32'd6);

        // wrap and overflow
        issue_chk(4'd0, 32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 1'b0);
        chk("wrap_ovf", W'(rsp_ovf), W'(OVF_EXP));
        issue_chk(4'd3, 32'd0, 32'd1, 1'b0, 32'hFFFF_FFFF, 1'b0);
        chk("sub_ovf", W'(rsp_ovf), W'(0));
        step();

        // reset while an op is in flight and one entry is queued
        rsp_ready = 1'b0;
        issue(4'd0, 32'd4, 32'd4, 1'b0);
        issue(4'd0, 32'd5, 32'd5, 1'b0);
        rstn = 1'b0;
        step();
        chk("mid_rst_valid", W'(rsp_valid), W'(0));
        chk("mid_rst_acc",   acc, '0);
        rstn = 1'b1;
        step();
        step();
        chk("mid_rst_nopush", W'(rsp_valid), W'(0));
        rsp_ready = 1'b1;
        issue_chk(4'hA, 32'd3, 32'd4, 1'b0, 32'd0, 1'b1);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            cmd_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) cmd_op = 4'($urandom_range(4, 15));
            else                           cmd_op = 4'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0:       cmd_a = 32'h7FFF_FFFF;
                1:       cmd_a = 32'h8000_0000;
                default: cmd_a = $urandom;
            endcase
            cmd_b       = ($urandom_range(0, 4) == 0) ? 32'd1 : $urandom;
            cmd_use_acc = 1'($urandom_range(0, 1));
            rsp_ready   = ($urandom_range(0, 3) != 0);
            rstn        = ($urandom_range(0, 99) != 0);
            step();
        end
        cmd_valid = 1'b0;
        rstn = 1'b1;
        rsp_ready = 1'b1;
        repeat (6) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
